// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared definitions for the IF stage.
//   NOP_INSTR_DEF  - bubble encoding (addi x0,x0,0)
//   RESET_PC_DEF   - default PC after reset
//   fetch_state_e  - fetch FSM encodings (FS_BOOT, FS_RUN, FS_HALT)
//   if_id_t        - IF/ID pipeline register payload
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_four;
    logic        vld;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with hold and bubble controls.
//   clk, rst_n - clock, async active-low reset (resets to a bubble)
//   hold       - keep current contents
//   bubble     - load the bubble; dominates hold
//   d          - next payload when neither hold nor bubble
//   q          - registered payload
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   hold,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t bub;
  assign bub = '{instr: NOP_INSTR, pc: 32'h0, pc_four: 32'h0, vld: 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      q <= bub;
    else if (bubble) q <= bub;
    else if (!hold)  q <= d;
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage + IF/ID register of the RV32I core.
//   clk, rst_n              - clock, async active-low reset
//   stall_if, flush_if      - hazard hold / IF/ID kill
//   redirect_vld/_pc        - EX-stage control-flow redirect
//   imem_req/_addr          - fetch request, address = pc
//   imem_ack/_rdata         - same-cycle ROM response
//   if_id_*                 - registered instruction, pc, pc+4, valid
//   misalign_err            - sticky, redirect target not word aligned
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_if,
  input  logic        flush_if,
  input  logic        redirect_vld,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_four,
  output logic        if_id_vld,
  output logic        misalign_err
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, pc_nxt, pc_four;
  logic         err_nxt, hold, bubble;
  if_id_t       d, q;

  assign pc_four   = pc + 32'd4;   // modulo 2^32, wrap is legal
  assign imem_addr = pc;
  assign imem_req  = (state == FS_RUN) && !stall_if;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FS_BOOT;
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      misalign_err <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    err_nxt   = misalign_err;
    hold      = 1'b0;
    bubble    = 1'b1;
    d         = '{instr: imem_rdata, pc: pc, pc_four: pc_four, vld: 1'b1};
    case (state)
      FS_BOOT: state_nxt = FS_RUN;
      FS_RUN: begin
        if (redirect_vld && (redirect_pc[1:0] != 2'b00)) begin
          // Bad target: stop fetching, pc stays at last aligned value.
          state_nxt = FS_HALT;
          err_nxt   = 1'b1;
        end else if (redirect_vld) begin
          pc_nxt = redirect_pc;
        end else if (flush_if) begin
          if (!stall_if && imem_ack) pc_nxt = pc_four;
        end else if (stall_if) begin
          hold   = 1'b1;
          bubble = 1'b0;
        end else if (imem_ack) begin
          bubble = 1'b0;
          pc_nxt = pc_four;
        end
        // no ack: bubble, pc retries the same address
      end
      default: ;  // HALT: bubble forever until reset
    endcase
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (hold),
    .bubble (bubble),
    .d      (d),
    .q      (q)
  );

  assign if_id_instr   = q.instr;
  assign if_id_pc      = q.pc;
  assign if_id_pc_four = q.pc_four;
  assign if_id_vld     = q.vld;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_if, flush_if, redirect_vld, imem_ack;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc_four;
  logic        if_id_vld, misalign_err;

  int vectors = 0;
  int errors  = 0;

  logic [96:0] exp_q[$];
  logic [96:0] exp_v, obs_v;
  localparam logic [96:0] BUB = {32'h0000_0013, 32'h0, 32'h0, 1'b0};

  fetch_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_if      (stall_if),
    .flush_if      (flush_if),
    .redirect_vld  (redirect_vld),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_pc_four (if_id_pc_four),
    .if_id_vld     (if_id_vld),
    .misalign_err  (misalign_err)
  );

  always #5 clk = ~clk;

  // ROM[i] = i, word indexed
  assign imem_rdata = imem_addr >> 2;
  assign obs_v = {if_id_instr, if_id_pc, if_id_pc_four, if_id_vld};

  function automatic logic [96:0] ent(input logic [31:0] a);
    return {a >> 2, a, a + 32'd4, 1'b1};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_if = 0; flush_if = 0; redirect_vld = 0; redirect_pc = 0; imem_ack = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #12;
    vectors++;
    if ({obs_v, imem_req, imem_addr, misalign_err} !== {BUB, 1'b0, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset: got ifid=%h req=%b addr=%h err=%b exp ifid=%h req=0 addr=0 err=0",
               obs_v, imem_req, imem_addr, misalign_err, BUB);
    end
    @(posedge clk); #1;
    rst_n = 1;
    #1;
    vectors++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL boot_req: got %b exp 0", imem_req);
    end
    exp_q.push_back(BUB);
    cyc();
    exp_v = exp_q.pop_front();
    vectors++;
    if (obs_v !== exp_v || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL boot_exit: got ifid=%h req=%b addr=%h exp ifid=%h req=1 addr=0",
               obs_v, imem_req, imem_addr, exp_v);
    end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(ent(32'(4 * k)));
      cyc();
      exp_v = exp_q.pop_front();
      vectors++;
      if (obs_v !== exp_v || imem_addr !== 32'(4 * (k + 1))) begin
        errors++;
        $display("FAIL stream%0d: got ifid=%h addr=%h exp ifid=%h addr=%h",
                 k, obs_v, imem_addr, exp_v, 32'(4 * (k + 1)));
      end
    end
  endtask

  task automatic test_stall();
    stall_if = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (imem_req !== 1'b0 || imem_addr !== 32'h8) begin
        errors++; $display("FAIL stall_req%0d: got req=%b addr=%h exp req=0 addr=8", k, imem_req, imem_addr);
      end
      exp_q.push_back(ent(32'h4));
      cyc();
      exp_v = exp_q.pop_front();
      vectors++;
      if (obs_v !== exp_v || imem_addr !== 32'h8) begin
        errors++; $display("FAIL stall_hold%0d: got ifid=%h addr=%h exp ifid=%h addr=8", k, obs_v, imem_addr, exp_v);
      end
    end
    stall_if = 0;
    exp_q.push_back(ent(32'h8));
    cyc();
    exp_v = exp_q.pop_front();
    vectors++;
    if (obs_v !== exp_v || imem_addr !== 32'hC) begin
      errors++; $display("FAIL stall_resume: got ifid=%h addr=%h exp ifid=%h addr=c", obs_v, imem_addr, exp_v);
    end
  endtask

  task automatic test_redirect_stall();
    stall_if = 1; redirect_vld = 1; redirect_pc = 32'h100;
    exp_q.push_back(BUB);
    cyc();
    exp_v = exp_q.pop_front();
    vectors++;
    if (obs_v !== exp_v || imem_addr !== 32'h100) begin
      errors++; $display("FAIL redir_bubble: got ifid=%h addr=%h exp ifid=%h addr=100", obs_v, imem_addr, exp_v);
    end
    idle_inputs();
    exp_q.push_back(ent(32'h100));
    cyc();
    exp_v = exp_q.pop_front();
    vectors++;
    if (obs_v !== exp_v) begin
      errors++; $display("FAIL redir_target: got ifid=%h exp %h", obs_v, exp_v);
    end
  endtask

  task automatic test_ack_gap();
    redirect_vld = 1; redirect_pc = 32'h20;
    cyc();
    redirect_vld = 0; imem_ack = 0;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(BUB);
      cyc();
      exp_v = exp_q.pop_front();
      vectors++;
      if (obs_v !== exp_v || imem_addr !== 32'h20 || imem_req !== 1'b1) begin
        errors++;
        $display("FAIL noack%0d: got ifid=%h addr=%h req=%b exp ifid=%h addr=20 req=1",
                 k, obs_v, imem_addr, imem_req, exp_v);
      end
    end
    imem_ack = 1;
    exp_q.push_back(ent(32'h20));
    cyc();
    exp_v = exp_q.pop_front();
    vectors++;
    if (obs_v !== exp_v || imem_addr !== 32'h24) begin
      errors++; $display("FAIL ack_resume: got ifid=%h addr=%h exp ifid=%h addr=24", obs_v, imem_addr, exp_v);
    end
  endtask

  task automatic test_flush();
    flush_if = 1;
    exp_q.push_back(BUB);
    cyc();
    exp_v = exp_q.pop_front();
    vectors++;
    if (obs_v !== exp_v || imem_addr !== 32'h28) begin
      errors++; $display("FAIL flush: got ifid=%h addr=%h exp ifid=%h addr=28", obs_v, imem_addr, exp_v);
    end
    flush_if = 0;
    exp_q.push_back(ent(32'h28));
    cyc();
    exp_v = exp_q.pop_front();
    vectors++;
    if (obs_v !== exp_v) begin
      errors++; $display("FAIL flush_next: got ifid=%h exp %h", obs_v, exp_v);
    end
  endtask

  task automatic test_wrap();
    redirect_vld = 1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect_vld = 0;
    exp_q.push_back({32'h3FFF_FFFF, 32'hFFFF_FFFC, 32'h0, 1'b1});
    cyc();
    exp_v = exp_q.pop_front();
    vectors++;
    if (obs_v !== exp_v || imem_addr !== 32'h0 || misalign_err !== 1'b0) begin
      errors++;
      $display("FAIL wrap: got ifid=%h addr=%h err=%b exp ifid=%h addr=0 err=0",
               obs_v, imem_addr, misalign_err, exp_v);
    end
    cyc();  // pc now 4
    #2;
    rst_n = 0;
    #1;
    vectors++;
    if ({obs_v, imem_req, imem_addr} !== {BUB, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL async_rst: got ifid=%h req=%b addr=%h exp ifid=%h req=0 addr=0",
               obs_v, imem_req, imem_addr, BUB);
    end
    @(posedge clk); #1;
    rst_n = 1;
    cyc();  // BOOT -> RUN
  endtask

  task automatic test_misalign();
    // pc = 0 in RUN; fetch one word to move pc to 4
    cyc();
    redirect_vld = 1; redirect_pc = 32'h102;
    cyc();
    vectors++;
    if (misalign_err !== 1'b1 || if_id_vld !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL misalign_entry: got err=%b vld=%b req=%b addr=%h exp err=1 vld=0 req=0 addr=4",
               misalign_err, if_id_vld, imem_req, imem_addr);
    end
    for (int k = 0; k < 4; k++) begin
      redirect_vld = k[0]; redirect_pc = 32'h200; stall_if = k[1]; flush_if = ~k[0];
      exp_q.push_back(BUB);
      cyc();
      exp_v = exp_q.pop_front();
      vectors++;
      if (obs_v !== exp_v || imem_req !== 1'b0 || misalign_err !== 1'b1 || imem_addr !== 32'h4) begin
        errors++;
        $display("FAIL halt%0d: got ifid=%h req=%b err=%b addr=%h exp ifid=%h req=0 err=1 addr=4",
                 k, obs_v, imem_req, misalign_err, imem_addr, exp_v);
      end
    end
    idle_inputs();
    rst_n = 0;
    #1;
    vectors++;
    if (misalign_err !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL halt_rst: got err=%b req=%b addr=%h exp err=0 req=0 addr=0",
               misalign_err, imem_req, imem_addr);
    end
    @(posedge clk); #1;
    rst_n = 1;
    cyc();
    vectors++;
    if (imem_req !== 1'b1 || if_id_vld !== 1'b0) begin
      errors++; $display("FAIL halt_reboot: got req=%b vld=%b exp req=1 vld=0", imem_req, if_id_vld);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_stall();
    test_ack_gap();
    test_flush();
    test_wrap();
    test_misalign();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
